// File: rtl/p4_router_vnp4_egress_meta_tagger.sv
// Egress metadata tagger between the Vitis Net P4 output stream and the
// router egress fabric.
//   clk, aresetn            : clock, asynchronous active-low reset (2-FF
//                             deassertion synchroniser inside)
//   s_t*                    : packet stream from VNP4
//   meta_in / meta_valid    : {ing_port, egr_spec, prio, byte_length} strobe
//   m_t*                    : registered packet stream to the fabric
//   m_egress_port, m_ingress_port, m_prio, m_byte_length
//                           : side-band, stable for every beat of a packet
//   cnt_clear               : synchronous clear of counters and sticky flags
//   fwd_cnt, drop_cnt       : per-port forwarded / global dropped packets
//   timeout_err             : sticky, packet dropped for missing metadata
//   meta_overflow           : sticky, metadata strobe lost on a full FIFO
module p4_router_vnp4_egress_meta_tagger #(
  parameter int                DATA_BYTES   = 64,
  parameter int                NUM_PORTS    = 8,
  parameter int                SPEC_W       = 4,
  parameter int                PRIO_W       = 3,
  parameter int                LEN_W        = 16,
  parameter logic [SPEC_W-1:0] DROP_SPEC    = 4'hF,
  parameter int                META_DEPTH   = 4,
  parameter int                META_TIMEOUT = 255,
  parameter int                CNT_W        = 32
) (
  input  logic                              clk,
  input  logic                              aresetn,
  input  logic [8*DATA_BYTES-1:0]           s_tdata,
  input  logic [DATA_BYTES-1:0]             s_tkeep,
  input  logic                              s_tlast,
  input  logic                              s_tvalid,
  output logic                              s_tready,
  input  logic [2*SPEC_W+PRIO_W+LEN_W-1:0]  meta_in,
  input  logic                              meta_valid,
  output logic [8*DATA_BYTES-1:0]           m_tdata,
  output logic [DATA_BYTES-1:0]             m_tkeep,
  output logic                              m_tlast,
  output logic                              m_tvalid,
  input  logic                              m_tready,
  output logic [$clog2(NUM_PORTS)-1:0]      m_egress_port,
  output logic [SPEC_W-1:0]                 m_ingress_port,
  output logic [PRIO_W-1:0]                 m_prio,
  output logic [LEN_W-1:0]                  m_byte_length,
  input  logic                              cnt_clear,
  output logic [NUM_PORTS*CNT_W-1:0]        fwd_cnt,
  output logic [CNT_W-1:0]                  drop_cnt,
  output logic                              timeout_err,
  output logic                              meta_overflow
);

  localparam int PORT_W = $clog2(NUM_PORTS);
  localparam int META_W = 2*SPEC_W + PRIO_W + LEN_W;
  localparam int AW     = $clog2(META_DEPTH);
  localparam int TMR_W  = $clog2(META_TIMEOUT + 1);
  localparam logic [SPEC_W:0] NP = (SPEC_W+1)'(NUM_PORTS);

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  // Reset: asserts asynchronously, releases two clocks after aresetn rises.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // Metadata FIFO
  logic [META_W-1:0] mem [META_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              full, empty, push, pop;

  assign full  = (count == (AW+1)'(META_DEPTH));
  assign empty = (count == '0);
  assign push  = meta_valid && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= meta_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  logic [META_W-1:0] head;
  logic [SPEC_W-1:0] head_ing, head_spec;
  logic [PRIO_W-1:0] head_prio;
  logic [LEN_W-1:0]  head_len;
  logic              head_bad;

  assign head      = mem[rd_ptr];
  assign head_ing  = head[META_W-1 -: SPEC_W];
  assign head_spec = head[PRIO_W+LEN_W +: SPEC_W];
  assign head_prio = head[LEN_W +: PRIO_W];
  assign head_len  = head[LEN_W-1:0];
  assign head_bad  = (head_spec == DROP_SPEC) || ({1'b0, head_spec} >= NP);

  // Control FSM
  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               ready, latch, tmo, fwd_inc, drop_inc, load;
  logic [PORT_W-1:0]  port_h;
  logic [SPEC_W-1:0]  ing_h;
  logic [PRIO_W-1:0]  prio_h;
  logic [LEN_W-1:0]   len_h;

  always_comb begin
    state_d  = state_q;
    timer_d  = '0;
    pop      = 1'b0;
    ready    = 1'b0;
    latch    = 1'b0;
    tmo      = 1'b0;
    fwd_inc  = 1'b0;
    drop_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_tvalid) begin
          if (!empty) begin
            pop = 1'b1;
            if (head_bad) state_d = DROP;
            else begin
              latch   = 1'b1;
              state_d = FWD;
            end
          end else if (TMR_W'(timer_q + 1'b1) == TMR_W'(META_TIMEOUT)) begin
            tmo     = 1'b1;
            state_d = DROP;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      FWD: begin
        ready = !m_tvalid || m_tready;
        if (s_tvalid && ready && s_tlast) begin
          fwd_inc = 1'b1;
          state_d = IDLE;
        end
      end
      DROP: begin
        ready = 1'b1;
        if (s_tvalid && s_tlast) begin
          drop_inc = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign s_tready = ready;
  assign load     = (state_q == FWD) && s_tvalid && ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      port_h  <= '0;
      ing_h   <= '0;
      prio_h  <= '0;
      len_h   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      if (latch) begin
        port_h <= head_spec[PORT_W-1:0];
        ing_h  <= head_ing;
        prio_h <= head_prio;
        len_h  <= head_len;
      end
    end
  end

  // Output register; side-band follows the beat that loads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tdata        <= '0;
      m_tkeep        <= '0;
      m_tlast        <= 1'b0;
      m_tvalid       <= 1'b0;
      m_egress_port  <= '0;
      m_ingress_port <= '0;
      m_prio         <= '0;
      m_byte_length  <= '0;
    end else if (load) begin
      m_tdata        <= s_tdata;
      m_tkeep        <= s_tkeep;
      m_tlast        <= s_tlast;
      m_tvalid       <= 1'b1;
      m_egress_port  <= port_h;
      m_ingress_port <= ing_h;
      m_prio         <= prio_h;
      m_byte_length  <= len_h;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

  // Counters and sticky flags; clear wins over a same-cycle event.
  logic [CNT_W-1:0] fwd_q [NUM_PORTS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) fwd_q[i] <= '0;
      drop_cnt      <= '0;
      timeout_err   <= 1'b0;
      meta_overflow <= 1'b0;
    end else if (cnt_clear) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) fwd_q[i] <= '0;
      drop_cnt      <= '0;
      timeout_err   <= 1'b0;
      meta_overflow <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_PORTS; i++)
        if (fwd_inc && (port_h == PORT_W'(i))) fwd_q[i] <= fwd_q[i] + 1'b1;
      if (drop_inc) drop_cnt <= drop_cnt + 1'b1;
      if (tmo) timeout_err <= 1'b1;
      if (meta_valid && full && !pop) meta_overflow <= 1'b1;
    end
  end

  always_comb begin
    fwd_cnt = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) fwd_cnt[i*CNT_W +: CNT_W] = fwd_q[i];
  end

endmodule

// File: doc/p4_router_vnp4_egress_meta_tagger.md
Name: p4_router_vnp4_egress_meta_tagger

Overview:
- Sits between the Vitis Net P4 egress stream (m_axis + user_metadata_out) and the router egress fabric.
- Pairs each output packet with its P4 metadata and maps egr_spec to a physical port index; holds tuser stable for every beat of the packet.
- Drops packets whose egress is invalid or whose metadata never arrives.
- Keeps per-port forward counters and global drop counters; parametrised in data width, port count, metadata FIFO depth and timeout.

Parameters:
DATA_BYTES, 64, tdata width in bytes
NUM_PORTS, 8, physical egress ports (2..16)
SPEC_W, 4, width of P4 egr_spec/ing_port fields
PRIO_W, 3, priority field width
LEN_W, 16, byte_length field width
DROP_SPEC, 4'hF, egr_spec value meaning explicit drop
META_DEPTH, 4, metadata FIFO depth (power of 2, >=2)
META_TIMEOUT, 255, cycles to wait for metadata at SOF before drop
CNT_W, 32, counter width

Ports:
clk  in  1  clock
aresetn  in  1  asynchronous active-low reset
s_tdata  in  8*DATA_BYTES  packet data from VNP4
s_tkeep  in  DATA_BYTES  byte enables
s_tlast  in  1  end of packet
s_tvalid  in  1  beat valid
s_tready  out  1  beat accepted
meta_in  in  2*SPEC_W+PRIO_W+LEN_W  {ing_port, egr_spec, prio, byte_length}
meta_valid  in  1  single-cycle metadata strobe
m_tdata  out  8*DATA_BYTES  output data
m_tkeep  out  DATA_BYTES  output byte enables
m_tlast  out  1  output end of packet
m_tvalid  out  1  output valid
m_tready  in  1  downstream ready
m_egress_port  out  $clog2(NUM_PORTS)  mapped port, stable across packet
m_ingress_port  out  SPEC_W  ing_port passthrough
m_prio  out  PRIO_W  priority
m_byte_length  out  LEN_W  byte length
cnt_clear  in  1  synchronous clear of counters and sticky flags
fwd_cnt  out  NUM_PORTS*CNT_W  packets forwarded, per port
drop_cnt  out  CNT_W  packets dropped (invalid spec or timeout)
timeout_err  out  1  sticky: SOF timeout occurred
meta_overflow  out  1  sticky: meta_valid while FIFO full

Behaviour:
- Reset (aresetn=0, asynchronous): all outputs 0; FIFO empty; state IDLE; counters and flags 0. Deassertion is synchronised internally with a 2-FF synchroniser.
- Metadata FIFO: meta_valid pushes meta_in.
  - Push when full: word discarded, meta_overflow=1.
  - Push and pop in the same cycle when full: both occur, no overflow.
- Output register: one stage; s_tready = fsm-permits && (!m_tvalid || m_tready). Latency 1 cycle in FWD. m_* stable while m_tvalid && !m_tready.
- FSM states:
  - IDLE: s_tready=0, timer=0.
    - FIFO non-empty and s_tvalid: pop and decode.
      - egr_spec==DROP_SPEC or egr_spec>=NUM_PORTS: go to DROP.
      - Otherwise: latch m_egress_port=egr_spec[$clog2(NUM_PORTS)-1:0] plus the other fields, then go to FWD.
    - FIFO empty and s_tvalid: timer++. When timer==META_TIMEOUT: timeout_err=1, go to DROP.
    - A metadata push on the timeout cycle is not consumed; it remains for the next packet.
  - FWD: beats pass through the output register. On accepted s_tlast: fwd_cnt[port]++, go to IDLE.
  - DROP: s_tready=1, beats discarded, m_tvalid not asserted. On accepted s_tlast: drop_cnt++, go to IDLE.
- Single-beat packets (SOF==EOF) follow the same rules and take 1 beat of FWD/DROP.
- IDLE→decode costs 1 bubble cycle per packet.
- Counters wrap modulo 2^CNT_W. cnt_clear has priority over an increment in the same cycle.
- Metadata fields are latched at decode. m_* side-band fields update only when the first beat of the next packet loads the output register.

Test Plan:
- Meta {ing=2,spec=5,prio=3,len=64} strobed 1 cycle before a 1-beat packet, m_tready=1 → one beat out 2 cycles after first s_tvalid; m_egress_port=5, m_prio=3; fwd_cnt[5]=1.
- 3-beat packet with spec=5, m_tready toggling 1/0 each cycle → all 3 beats delivered in order; m_tdata and m_egress_port held during stalls; tlast on beat 3.
- spec=4'hF then spec=9 (NUM_PORTS=8), 2-beat packets → no m_tvalid; drop_cnt=2; s_tready high through both packets.
- Packet with no metadata and META_TIMEOUT=10 → s_tready low for 10 cycles, then packet drained; timeout_err=1, drop_cnt=1. A following packet with metadata forwards normally.
- 5 meta strobes back-to-back with META_DEPTH=4 and no packets → meta_overflow=1. Then 4 packets forward using the first 4 metadata words in order.
- aresetn pulsed low mid-packet in FWD → all outputs 0 immediately; the next upstream beat is treated as SOF; cnt_clear zeroes counters while a tlast increment coincides.
